trig_wb_ctrl_regs: RTL and testbench

//  Wishbone responder holding the trigger-path control registers: run control, trigger

---
 rtl/trig_wb_ctrl_regs.sv | 188 ++++++++++++++++++
 tb/tb_trig_wb_ctrl_regs.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_wb_ctrl_regs.sv
// Wishbone responder for the trigger-path control registers: run control,
// trigger mask, readout offset, trigger latency and a software-trigger queue.
// Everything lives in the WB clock domain.
module trig_wb_ctrl_regs #(
  parameter int unsigned LATENCY_DEFAULT = 200,
  parameter logic [27:0] MASK_DEFAULT    = 28'hFFFFFFF,
  parameter int unsigned SOFT_DEPTH_LOG2 = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [13:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        run_enable_o,
  output logic        run_reset_o,
  output logic        run_stop_o,
  output logic [27:0] trigmask_o,
  output logic        trigmask_update_o,
  output logic [15:0] trig_offset_o,
  output logic [15:0] trig_latency_o,
  output logic        soft_trig_req_o,
  input  logic        soft_trig_ack_i
);

  localparam int unsigned   CW   = SOFT_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL = CW'(2 ** SOFT_DEPTH_LOG2);

  localparam logic [11:0] A_RUNCTRL  = 12'h000;
  localparam logic [11:0] A_TRIGMASK = 12'h040;
  localparam logic [11:0] A_LATENCY  = 12'h041;
  localparam logic [11:0] A_OFFSET   = 12'h042;
  localparam logic [11:0] A_SOFTTRIG = 12'h044;
  localparam logic [11:0] A_SOFTSTAT = 12'h045;

  logic          r_ack;
  logic [31:0]   r_dat;
  logic          r_run_enable;
  logic          r_run_reset;
  logic          r_run_stop;
  logic [27:0]   r_trigmask;
  logic          r_tm_pend;
  logic          r_tm_update;
  logic [15:0]   r_offset;
  logic [15:0]   r_latency;
  logic [CW-1:0] r_count;
  logic [15:0]   r_dropped;
  logic          r_req;

  logic          w_acc;
  logic          w_wr;
  logic          w_rd;
  logic [11:0]   w_word;
  logic          w_enq;
  logic          w_deq;
  logic          w_drop;
  logic [CW-1:0] w_count_next;
  logic [15:0]   w_count16;
  logic [31:0]   w_rdata;
  logic          w_unused_bits;

  // A new access is one that has not yet been acked; state commits on the
  // same edge that raises ack, so the read mux still sees pre-update values.
  assign w_acc  = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr   = w_acc & wb_we_i;
  assign w_rd   = w_acc & ~wb_we_i;
  assign w_word = wb_adr_i[13:2];
  assign w_enq  = w_wr & (w_word == A_SOFTTRIG) & wb_sel_i[0] & wb_dat_i[0];
  assign w_deq  = soft_trig_ack_i & (r_count != '0);

  assign w_unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:28]};

  // Soft-trigger queue next count; enqueue+dequeue together is a no-op even when full.
  always_comb begin
    w_count_next = r_count;
    w_drop       = 1'b0;
    if (w_enq && !w_deq) begin
      if (r_count == FULL) w_drop = 1'b1;
      else                 w_count_next = r_count + 1'b1;
    end else if (!w_enq && w_deq) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Read data mux for the register map.
  always_comb begin
    w_count16           = '0;
    w_count16[CW-1:0]   = r_count;
    w_rdata             = '0;
    case (w_word)
      A_RUNCTRL:  w_rdata = {29'b0, 1'b0, r_run_enable, 1'b0};
      A_TRIGMASK: w_rdata = {4'b0, r_trigmask};
      A_LATENCY:  w_rdata = {16'b0, r_latency};
      A_OFFSET:   w_rdata = {16'b0, r_offset};
      A_SOFTSTAT: w_rdata = {r_dropped, w_count16};
      default:    w_rdata = '0;
    endcase
  end

  // Bus handshake and registered read data (zero whenever ack is low).
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_rd ? w_rdata : '0;
    end
  end

  // Run control level and single-cycle run pulses.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_run_enable <= 1'b0;
      r_run_reset  <= 1'b0;
      r_run_stop   <= 1'b0;
    end else begin
      r_run_reset <= w_wr & (w_word == A_RUNCTRL) & wb_sel_i[0] & wb_dat_i[0];
      r_run_stop  <= w_wr & (w_word == A_RUNCTRL) & wb_sel_i[0] & wb_dat_i[2];
      if (w_wr && (w_word == A_RUNCTRL) && wb_sel_i[0]) r_run_enable <= wb_dat_i[1];
    end
  end

  // Trigger mask with byte enables; update pulse lands the cycle after ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_trigmask  <= MASK_DEFAULT;
      r_tm_pend   <= 1'b0;
      r_tm_update <= 1'b0;
    end else begin
      r_tm_pend   <= w_wr & (w_word == A_TRIGMASK) & (|wb_sel_i);
      r_tm_update <= r_tm_pend;
      if (w_wr && (w_word == A_TRIGMASK)) begin
        if (wb_sel_i[0]) r_trigmask[7:0]   <= wb_dat_i[7:0];
        if (wb_sel_i[1]) r_trigmask[15:8]  <= wb_dat_i[15:8];
        if (wb_sel_i[2]) r_trigmask[23:16] <= wb_dat_i[23:16];
        if (wb_sel_i[3]) r_trigmask[27:24] <= wb_dat_i[27:24];
      end
    end
  end

  // Latency and offset registers with byte enables.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_latency <= 16'(LATENCY_DEFAULT);
      r_offset  <= '0;
    end else begin
      if (w_wr && (w_word == A_LATENCY)) begin
        if (wb_sel_i[0]) r_latency[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) r_latency[15:8] <= wb_dat_i[15:8];
      end
      if (w_wr && (w_word == A_OFFSET)) begin
        if (wb_sel_i[0]) r_offset[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) r_offset[15:8] <= wb_dat_i[15:8];
      end
    end
  end

  // Soft-trigger queue count, request level and saturating drop counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_count   <= '0;
      r_req     <= 1'b0;
      r_dropped <= '0;
    end else begin
      r_count <= w_count_next;
      r_req   <= (w_count_next != '0);
      if (w_wr && (w_word == A_SOFTSTAT)) r_dropped <= '0;
      else if (w_drop && (r_dropped != '1)) r_dropped <= r_dropped + 1'b1;
    end
  end

  assign wb_ack_o          = r_ack;
  assign wb_dat_o          = r_dat;
  assign run_enable_o      = r_run_enable;
  assign run_reset_o       = r_run_reset;
  assign run_stop_o        = r_run_stop;
  assign trigmask_o        = r_trigmask;
  assign trigmask_update_o = r_tm_update;
  assign trig_offset_o     = r_offset;
  assign trig_latency_o    = r_latency;
  assign soft_trig_req_o   = r_req;

endmodule

// File: tb/tb_trig_wb_ctrl_regs.sv
// Directed bench for trig_wb_ctrl_regs: a vector table of single accesses
// followed by hand-written multi-cycle sequences.
module tb_trig_wb_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [13:0] adr;
  logic [31:0] dat;
  logic        ack;
  logic [31:0] rdat;
  logic        run_en, run_rst, run_stp;
  logic [27:0] tmask;
  logic        tm_upd;
  logic [15:0] toff, tlat;
  logic        sreq;
  logic        sack;

  int n_chk  = 0;
  int n_pass = 0;
  int n_rr   = 0;
  int n_rs   = 0;
  int n_tu   = 0;
  logic        upd_at_ack;
  logic [31:0] rd;
  int          nack;

  typedef struct {
    logic        we;
    logic [13:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[14];

  trig_wb_ctrl_regs #(
    .LATENCY_DEFAULT(200),
    .MASK_DEFAULT(28'hFFFFFFF),
    .SOFT_DEPTH_LOG2(3)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_we_i(we),
    .wb_sel_i(sel),
    .wb_adr_i(adr),
    .wb_dat_i(dat),
    .wb_ack_o(ack),
    .wb_dat_o(rdat),
    .run_enable_o(run_en),
    .run_reset_o(run_rst),
    .run_stop_o(run_stp),
    .trigmask_o(tmask),
    .trigmask_update_o(tm_upd),
    .trig_offset_o(toff),
    .trig_latency_o(tlat),
    .soft_trig_req_o(sreq),
    .soft_trig_ack_i(sack)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Advance to the next falling edge and tally pulse outputs seen there.
  task automatic tick();
    @(negedge clk);
    if (run_rst) n_rr++;
    if (run_stp) n_rs++;
    if (tm_upd)  n_tu++;
  endtask

  // One WB access; optional soft ack on the commit edge and extra cyc hold.
  task automatic xfer(input logic w, input logic [13:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic sa, input int hold,
                      output logic [31:0] rdv, output int acks);
    logic got;
    got  = 1'b0;
    rdv  = '0;
    acks = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d; sack = sa;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      sack = 1'b0;
      if (ack) begin
        got = 1'b1;
        rdv = rdat;
        upd_at_ack = tm_upd;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL ack_timeout adr=0x%04h: got no ack expected ack within 4 cycles", a);
    end else acks = 1;
    stb = 1'b0; we = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (ack) acks++;
    end
    cyc = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    logic [31:0] x;
    int k;
    xfer(1'b1, a, 4'hF, d, 1'b0, 0, x, k);
  endtask

  task automatic rdchk(input string nm, input logic [13:0] a, input logic [31:0] exp);
    logic [31:0] x;
    int k;
    xfer(1'b0, a, 4'hF, 32'h0, 1'b0, 0, x, k);
    check(nm, x, exp);
  endtask

  task automatic sack_pulse();
    sack = 1'b1;
    tick();
    sack = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b0, 14'h104, 4'hF, 32'h0,        1'b1, 32'd200};
    vt[1]  = '{1'b0, 14'h100, 4'hF, 32'h0,        1'b1, 32'h0FFFFFFF};
    vt[2]  = '{1'b0, 14'h000, 4'hF, 32'h0,        1'b1, 32'h0};
    vt[3]  = '{1'b0, 14'h108, 4'hF, 32'h0,        1'b1, 32'h0};
    vt[4]  = '{1'b0, 14'h114, 4'hF, 32'h0,        1'b1, 32'h0};
    vt[5]  = '{1'b0, 14'h200, 4'hF, 32'h0,        1'b1, 32'h0};
    vt[6]  = '{1'b1, 14'h100, 4'hF, 32'hFFFF0000, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 14'h100, 4'hF, 32'h0,        1'b1, 32'h0FFF0000};
    vt[8]  = '{1'b1, 14'h108, 4'h2, 32'hAABBCCDD, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 14'h10B, 4'hF, 32'h0,        1'b1, 32'h0000CC00};
    vt[10] = '{1'b1, 14'h000, 4'h0, 32'h00000007, 1'b0, 32'h0};
    vt[11] = '{1'b0, 14'h000, 4'hF, 32'h0,        1'b1, 32'h0};
    vt[12] = '{1'b1, 14'h200, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
    vt[13] = '{1'b0, 14'h104, 4'hF, 32'h0,        1'b1, 32'd200};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0; sack = 1'b0;
    upd_at_ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_ack",  {31'b0, ack}, 32'h0);
    check("rst_dat",  rdat, 32'h0);
    check("rst_run",  {31'b0, run_en}, 32'h0);
    check("rst_mask", {4'b0, tmask}, 32'h0FFFFFFF);
    check("rst_lat",  {16'b0, tlat}, 32'd200);
    check("rst_off",  {16'b0, toff}, 32'h0);
    check("rst_req",  {31'b0, sreq}, 32'h0);

    // Vector table
    n_tu = 0;
    for (int i = 0; i < 14; i++) begin
      xfer(vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, 1'b0, 0, rd, nack);
      if (vt[i].chk) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
    end
    check("tbl_mask_out", {4'b0, tmask}, 32'h0FFF0000);
    check("tbl_off_out",  {16'b0, toff}, 32'h0000CC00);
    check("tbl_tm_upd_cnt", n_tu, 1);
    check("tbl_run_pulses", n_rr + n_rs, 0);

    // Byte-3 mask write; update pulse one cycle after ack
    n_tu = 0;
    xfer(1'b1, 14'h100, 4'h8, 32'h0A000000, 1'b0, 0, rd, nack);
    check("tm_upd_at_ack", {31'b0, upd_at_ack}, 32'h0);
    check("tm_upd_cnt",    n_tu, 1);
    check("tm_byte3",      {4'b0, tmask}, 32'h0AFF0000);

    // Partial write with cyc held three cycles
    xfer(1'b1, 14'h104, 4'h3, 32'h12345678, 1'b0, 2, rd, nack);
    check("hold_ack_count", nack, 1);
    check("lat_out", {16'b0, tlat}, 32'h00005678);
    rdchk("lat_rd", 14'h104, 32'h00005678);

    // Run control
    n_rr = 0; n_rs = 0;
    wr(14'h000, 32'h2);
    check("rr_none", n_rr, 0);
    wr(14'h000, 32'h3);
    check("rr_one", n_rr, 1);
    check("run_en", {31'b0, run_en}, 32'h1);
    rdchk("run_rd", 14'h000, 32'h2);
    wr(14'h000, 32'h4);
    check("rs_one", n_rs, 1);
    check("run_en_off", {31'b0, run_en}, 32'h0);
    check("rr_still_one", n_rr, 1);

    // Soft queue: fill three, drain three, stray ack at empty
    for (int i = 0; i < 3; i++) wr(14'h110, 32'h1);
    rdchk("sq_cnt3", 14'h114, 32'h3);
    check("sq_req1", {31'b0, sreq}, 32'h1);
    for (int i = 0; i < 3; i++) sack_pulse();
    tick();
    check("sq_req0", {31'b0, sreq}, 32'h0);
    rdchk("sq_cnt0", 14'h114, 32'h0);
    sack_pulse();
    rdchk("sq_empty_ack", 14'h114, 32'h0);
    wr(14'h110, 32'h2);
    rdchk("sq_bit0_only", 14'h114, 32'h0);

    // Overflow and drop counter
    for (int i = 0; i < 10; i++) wr(14'h110, 32'h1);
    rdchk("sq_full_drop", 14'h114, 32'h00020008);
    check("sq_full_req", {31'b0, sreq}, 32'h1);
    wr(14'h114, 32'h0);
    rdchk("sq_drop_clr", 14'h114, 32'h00000008);

    // Enqueue and ack together when full
    xfer(1'b1, 14'h110, 4'hF, 32'h1, 1'b1, 0, rd, nack);
    rdchk("sq_enq_ack_full", 14'h114, 32'h00000008);
    sack_pulse();
    rdchk("sq_cnt7", 14'h114, 32'h00000007);

    // Reset during an acked access clears ack and empties the queue
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 14'h114; sel = 4'hF;
    tick();
    check("mid_ack_before", {31'b0, ack}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("mid_ack_cleared", {31'b0, ack}, 32'h0);
    check("mid_req_cleared", {31'b0, sreq}, 32'h0);
    // Write held under reset must have no effect
    we = 1'b1; adr = 14'h104; dat = 32'h00001111;
    tick();
    tick();
    check("mid_no_side_effect", {16'b0, tlat}, 32'd200);
    check("mid_ack_held_rst", {31'b0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    tick();
    rdchk("post_rst_stat", 14'h114, 32'h0);
    rdchk("post_rst_mask", 14'h100, 32'h0FFFFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
